// File: rtl/hls_test_pkg.sv
// Shared definitions for the HLS method-block self-test sequencer:
// state encoding and constant-function helpers used to size counters.
package hls_test_pkg;

    // Sequencer states; numeric values are visible on the state debug output.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_REQ    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_NEXT   = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Larger of two integers.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hls_test_timer.sv
// Saturating up-counter shared by the settle delay and the per-test wait.
// A load starts a new interval at 1, so the count equals the number of
// cycles elapsed since the loading cycle.
module hls_test_timer
    import hls_test_pkg::*;
#(
    parameter int CNT_W       = 14,
    parameter int START_DELAY = 100,
    parameter int MIN_WAIT    = 5,
    parameter int TIMEOUT     = 10000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic settle_done,
    output logic min_reached,
    output logic timed_out
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(START_DELAY - 1);
    localparam logic [CNT_W-1:0] MIN_COUNT   = CNT_W'(MIN_WAIT);
    localparam logic [CNT_W-1:0] TO_COUNT    = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count;

    // Counter: load restarts at 1, enable counts up and sticks at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(1);
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    // Threshold compares consumed by the sequencer FSM.
    always_comb begin
        settle_done = (count >= SETTLE_LAST);
        min_reached = (count >= MIN_COUNT);
        timed_out   = (count >= TO_COUNT);
    end

endmodule

// File: rtl/hls_test_sequencer.sv
// Self-test sequencer for HLS method blocks with a req/busy/return handshake.
// Handshake: test_req[i] is a single-cycle one-hot request for channel i;
// the channel is considered complete once at least MIN_WAIT cycles have
// passed since the request and test_busy[i] is low, at which point
// test_return[i] is sampled (1 = pass). Channels are run in index order.
module hls_test_sequencer
    import hls_test_pkg::*;
#(
    parameter int NUM_TESTS   = 4,
    parameter int IDX_W       = 32,
    parameter int START_DELAY = 100,
    parameter int MIN_WAIT    = 5,
    parameter int TIMEOUT     = 10000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [NUM_TESTS-1:0] test_req,
    input  logic [NUM_TESTS-1:0] test_busy,
    input  logic [NUM_TESTS-1:0] test_return,
    output logic [IDX_W-1:0]     test_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_TESTS-1:0] fail_mask,
    output logic [NUM_TESTS-1:0] timeout_mask,
    output logic [2:0]           state_dbg
);

    localparam int CNT_W = clog2(max_int(TIMEOUT, START_DELAY) + 1);
    localparam int IW    = (NUM_TESTS > 1) ? clog2(NUM_TESTS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_TESTS - 1);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] idx;

    logic tmr_load;
    logic tmr_en;
    logic settle_done;
    logic min_reached;
    logic timed_out;

    logic campaign_clr;
    logic idx_inc;
    logic set_fail;
    logic set_tmo;
    logic pass_upd;

    hls_test_timer #(
        .CNT_W       (CNT_W),
        .START_DELAY (START_DELAY),
        .MIN_WAIT    (MIN_WAIT),
        .TIMEOUT     (TIMEOUT)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .load        (tmr_load),
        .enable      (tmr_en),
        .settle_done (settle_done),
        .min_reached (min_reached),
        .timed_out   (timed_out)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath controls; completion takes priority over timeout.
    always_comb begin
        state_nxt    = state;
        tmr_load     = 1'b0;
        tmr_en       = 1'b0;
        campaign_clr = 1'b0;
        idx_inc      = 1'b0;
        set_fail     = 1'b0;
        set_tmo      = 1'b0;
        pass_upd     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    campaign_clr = 1'b1;
                    tmr_load     = 1'b1;
                    state_nxt    = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_done) begin
                    state_nxt = ST_REQ;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_REQ: begin
                tmr_load  = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (min_reached && !test_busy[idx]) begin
                    set_fail  = !test_return[idx];
                    state_nxt = ST_NEXT;
                end else if (timed_out) begin
                    set_fail  = 1'b1;
                    set_tmo   = 1'b1;
                    state_nxt = ST_NEXT;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_NEXT: begin
                if (idx == LAST_IDX) begin
                    pass_upd  = 1'b1;
                    state_nxt = ST_FINISH;
                end else begin
                    idx_inc   = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_FINISH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Test index, result masks and the pass level; held until the next accepted start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx          <= '0;
            fail_mask    <= '0;
            timeout_mask <= '0;
            pass         <= 1'b0;
        end else begin
            if (campaign_clr) begin
                idx          <= '0;
                fail_mask    <= '0;
                timeout_mask <= '0;
                pass         <= 1'b0;
            end
            if (idx_inc) begin
                idx <= idx + 1'b1;
            end
            if (set_fail) begin
                fail_mask[idx] <= 1'b1;
            end
            if (set_tmo) begin
                timeout_mask[idx] <= 1'b1;
            end
            // fail_mask is final by the NEXT cycle of the last test, so pass
            // is already valid alongside the done pulse.
            if (pass_upd) begin
                pass <= ~|fail_mask;
            end
        end
    end

    // Outputs decoded from state so a reset clears them without waiting for a clock.
    always_comb begin
        test_req = '0;
        if (state == ST_REQ) begin
            test_req[idx] = 1'b1;
        end
        test_idx         = '0;
        test_idx[IW-1:0] = idx;
        busy      = (state == ST_SETTLE) || (state == ST_REQ) ||
                    (state == ST_WAIT)   || (state == ST_NEXT);
        done      = (state == ST_FINISH);
        state_dbg = state;
    end

endmodule

// File: tb/tb_hls_test_sequencer.sv
// Bench for hls_test_sequencer: NUM_TESTS=4, START_DELAY=100, MIN_WAIT=5, TIMEOUT=50.
// Channel models respond to each request with a programmable busy length.
module tb_hls_test_sequencer;

    localparam int NT      = 4;
    localparam int SD      = 100;
    localparam int MW      = 5;
    localparam int TO      = 50;
    localparam int FOREVER = 255;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic [NT-1:0] test_req;
    logic [NT-1:0] test_busy;
    logic [NT-1:0] test_return;
    logic [31:0]   test_idx;
    logic          busy;
    logic          done;
    logic          pass;
    logic [NT-1:0] fail_mask;
    logic [NT-1:0] timeout_mask;
    logic [2:0]    state_dbg;

    hls_test_sequencer #(
        .NUM_TESTS   (NT),
        .IDX_W       (32),
        .START_DELAY (SD),
        .MIN_WAIT    (MW),
        .TIMEOUT     (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .test_req     (test_req),
        .test_busy    (test_busy),
        .test_return  (test_return),
        .test_idx     (test_idx),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .fail_mask    (fail_mask),
        .timeout_mask (timeout_mask),
        .state_dbg    (state_dbg)
    );

    // Edge counter; cycle k of a campaign is e - start_e at the negedge.
    int e       = 0;
    int start_e = 0;
    always @(posedge clk) e <= e + 1;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    logic [31:0] req_q[$];
    logic [31:0] done_q[$];

    int            lat[NT];
    int            rem[NT];
    logic [NT-1:0] ret_v = '0;
    logic [NT-1:0] exp_fail;
    logic [NT-1:0] exp_tmo;

    assign test_return = ret_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- method channel models ----------------
    // Busy rises the cycle after req and falls lat cycles after req.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            test_busy <= '0;
            for (int i = 0; i < NT; i++) rem[i] <= 0;
        end else begin
            for (int i = 0; i < NT; i++) begin
                if (test_req[i]) begin
                    if (lat[i] >= FOREVER) begin
                        test_busy[i] <= 1'b1;
                        rem[i]       <= 0;
                    end else if (lat[i] <= 1) begin
                        test_busy[i] <= 1'b0;
                        rem[i]       <= 0;
                    end else begin
                        test_busy[i] <= 1'b1;
                        rem[i]       <= lat[i] - 1;
                    end
                end else if (rem[i] > 0) begin
                    rem[i] <= rem[i] - 1;
                    if (rem[i] == 1) test_busy[i] <= 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [31:0] act;
        int k;
        if (reset) begin
            k = e - start_e;
            if (|test_req) begin
                act = {test_req, test_idx[11:0], 16'(k)};
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got %0h expected none", act);
                end else begin
                    check("req", act, req_q.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                act = {7'd0, pass, fail_mask, timeout_mask, 16'(k)};
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got %0h expected none", act);
                end else begin
                    check("done", act, done_q.pop_front());
                end
            end
        end
    end

    // Reference timing: each test takes REQ + wait + NEXT cycles.
    task automatic push_campaign();
        int r;
        int d;
        logic [NT-1:0] f;
        logic [NT-1:0] t;
        logic [3:0] oh;
        r = SD;
        f = '0;
        t = '0;
        for (int i = 0; i < NT; i++) begin
            oh = '0;
            oh[i] = 1'b1;
            req_q.push_back({oh, 12'(i), 16'(r)});
            if (lat[i] <= TO) begin
                d = (lat[i] > MW) ? lat[i] : MW;
                if (!ret_v[i]) f[i] = 1'b1;
            end else begin
                d = TO;
                f[i] = 1'b1;
                t[i] = 1'b1;
            end
            r = r + d + 2;
        end
        done_q.push_back({7'd0, ~|f, f, t, 16'(r)});
        exp_fail = f;
        exp_tmo  = t;
    endtask

    // ---------------- driver tasks ----------------
    task automatic accept_start();
        @(posedge clk);
        #1 start = 1'b1;
        start_e = e;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic pulse_at(input int k);
        do begin
            @(posedge clk);
            #1;
        end while (e < start_e + k);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_campaign();
        int c0;
        push_campaign();
        c0 = done_cnt;
        accept_start();
        for (int n = 0; n < 2000 && done_cnt == c0; n++) begin
            @(negedge clk);
            #1;
        end
        if (done_cnt == c0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 2000 cycles");
        end
        @(negedge clk);
        check("done_width", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [NT-1:0][7:0] lat;
        logic [NT-1:0]      ret;
        logic [NT-1:0]      fail;
        logic [NT-1:0]      tmo;
        logic               pass;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int c0;
        vecs[0] = '{lat: {8'd7, 8'd7, 8'd7, 8'd7},     ret: 4'b1111, fail: 4'b0000, tmo: 4'b0000, pass: 1'b1};
        vecs[1] = '{lat: {8'd7, 8'd7, 8'd7, 8'd7},     ret: 4'b1011, fail: 4'b0100, tmo: 4'b0000, pass: 1'b0};
        vecs[2] = '{lat: {8'd7, 8'd7, 8'd255, 8'd7},   ret: 4'b1111, fail: 4'b0010, tmo: 4'b0010, pass: 1'b0};
        vecs[3] = '{lat: {8'd0, 8'd0, 8'd0, 8'd0},     ret: 4'b1111, fail: 4'b0000, tmo: 4'b0000, pass: 1'b1};
        vecs[4] = '{lat: {8'd51, 8'd7, 8'd7, 8'd50},   ret: 4'b1101, fail: 4'b1010, tmo: 4'b1000, pass: 1'b0};
        vecs[5] = '{lat: {8'd1, 8'd6, 8'd5, 8'd4},     ret: 4'b1111, fail: 4'b0000, tmo: 4'b0000, pass: 1'b1};
        for (int i = 0; i < NT; i++) lat[i] = 0;

        // Reset state.
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(test_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_fail", 32'(fail_mask), 32'd0);
        check("rst_tmo", 32'(timeout_mask), 32'd0);
        check("rst_idx", test_idx, 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        #2 reset = 1'b1;

        // Table-driven campaigns.
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < NT; i++) lat[i] = int'(vecs[v].lat[i]);
            ret_v = vecs[v].ret;
            run_campaign();
            check($sformatf("v%0d_fail", v), 32'(fail_mask), 32'(vecs[v].fail));
            check($sformatf("v%0d_tmo", v), 32'(timeout_mask), 32'(vecs[v].tmo));
            check($sformatf("v%0d_pass", v), 32'(pass), 32'(vecs[v].pass));
        end

        // Random campaigns checked against the reference model.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NT; i++) lat[i] = $urandom_range(0, 55);
            ret_v = 4'($urandom_range(0, 15));
            run_campaign();
            check($sformatf("rnd%0d_fail", r), 32'(fail_mask), 32'(exp_fail));
            check($sformatf("rnd%0d_tmo", r), 32'(timeout_mask), 32'(exp_tmo));
            check($sformatf("rnd%0d_pass", r), 32'(pass), 32'(~|exp_fail));
        end

        // Reset during WAIT of test 1.
        for (int i = 0; i < NT; i++) lat[i] = 7;
        ret_v = 4'b1110;
        req_q.push_back({4'b0001, 12'd0, 16'd100});
        req_q.push_back({4'b0010, 12'd1, 16'd109});
        accept_start();
        do begin
            @(posedge clk);
            #1;
        end while (e < start_e + 112);
        check("pre_rst_fail", 32'(fail_mask), 32'h1);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_req", 32'(test_req), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_fail", 32'(fail_mask), 32'd0);
        check("mid_rst_tmo", 32'(timeout_mask), 32'd0);
        check("mid_rst_idx", test_idx, 32'd0);
        check("mid_rst_state", 32'(state_dbg), 32'd0);
        check("mid_rst_reqs_left", 32'(req_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        ret_v = 4'b1111;
        run_campaign();
        check("rerun_pass", 32'(pass), 32'd1);
        check("rerun_fail", 32'(fail_mask), 32'd0);

        // Starts during a campaign and in the FINISH cycle are ignored.
        push_campaign();
        c0 = done_cnt;
        accept_start();
        pulse_at(50);
        pulse_at(120);
        pulse_at(136);
        repeat (150) @(posedge clk);
        #1;
        check("ign_done_count", 32'(done_cnt - c0), 32'd1);
        check("ign_reqs_left", 32'(req_q.size()), 32'd0);
        check("ign_done_left", 32'(done_q.size()), 32'd0);
        check("ign_busy", 32'(busy), 32'd0);
        check("ign_pass", 32'(pass), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
